// File: rtl/pkg_enum_unswap_fifo_pkg.sv
// Shared token type for the swap/unswap path: the test_t enum, its width and
// the swap/unswap mapping functions.
package pkg;

    typedef enum logic {
        TEST_1 = 1'b0,
        TEST_2 = 1'b1
    } test_t;

    localparam int TEST_W = $bits(test_t);

    function automatic test_t swap(input test_t x);
        case (x)
            TEST_1:  return TEST_2;
            default: return TEST_1;
        endcase
    endfunction

    // Inverse of swap, so unswap(swap(x)) == x for every enumerator.
    function automatic test_t unswap(input test_t x);
        case (x)
            TEST_2:  return TEST_1;
            default: return TEST_2;
        endcase
    endfunction

endpackage

// File: rtl/pkg_enum_unswap_fifo_if.sv
// Stream bundle for pkg_enum_unswap_fifo: swapped tokens in, restored tokens out.
// Handshake: a token moves when valid && ready on the same rising edge; the
// producer holds data/valid stable while valid is high and ready is low.
interface pkg_enum_unswap_fifo_if #(
    parameter int CNT_W = 3
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    pkg::test_t       in_data;
    logic             out_valid;
    logic             out_ready;
    pkg::test_t       out_data;
    logic [CNT_W-1:0] level;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );

endinterface

// File: rtl/pkg_enum_unswap_fifo_core.sv
// DEPTH-entry FIFO of test_t tokens with read/write pointers, occupancy level
// and a synchronous flush that overrides push and pop.
module pkg_enum_fifo_core
    import pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  test_t            wr_data,
    output test_t            rd_data,
    output logic [CNT_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    test_t            mem_q [DEPTH];
    test_t            mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + CNT_W'(1);
                2'b01:   level_d = level_q - CNT_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Storage is reset too, so the read port shows TEST_1 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TEST_1;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/pkg_enum_unswap_fifo.sv
// Receive-side unswap FIFO: restores pkg::unswap(in_data) on write and buffers it.
// Optional pop statistics (cnt_t1/cnt_t2) enabled by PKG_ENUM_UNSWAP_STATS_EN.
module pkg_enum_unswap_fifo
    import pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    pkg_enum_unswap_fifo_if.slave  bus
`ifdef PKG_ENUM_UNSWAP_STATS_EN
    ,
    output logic [15:0]            cnt_t1,
    output logic [15:0]            cnt_t2
`endif
);

    logic             full;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    test_t            rd_data;
    logic [CNT_W-1:0] level;

    // Ready depends only on the stored level, never on out_ready.
    assign full      = (level == CNT_W'(DEPTH));
    assign in_ready  = !full && !bus.flush;
    assign out_valid = (level != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready && !bus.flush;

    pkg_enum_fifo_core #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .push    (push),
        .pop     (pop),
        .wr_data (unswap(bus.in_data)),
        .rd_data (rd_data),
        .level   (level)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = rd_data;
    assign bus.level     = level;

`ifdef PKG_ENUM_UNSWAP_STATS_EN
    logic [15:0] cnt_t1_q, cnt_t1_d;
    logic [15:0] cnt_t2_q, cnt_t2_d;

    // Counters survive flush; only rst clears them.
    always_comb begin
        cnt_t1_d = cnt_t1_q;
        cnt_t2_d = cnt_t2_q;
        if (pop) begin
            if (rd_data == TEST_1) begin
                if (cnt_t1_q != 16'hFFFF) cnt_t1_d = cnt_t1_q + 16'd1;
            end else begin
                if (cnt_t2_q != 16'hFFFF) cnt_t2_d = cnt_t2_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_t1_q <= '0;
            cnt_t2_q <= '0;
        end else begin
            cnt_t1_q <= cnt_t1_d;
            cnt_t2_q <= cnt_t2_d;
        end
    end

    assign cnt_t1 = cnt_t1_q;
    assign cnt_t2 = cnt_t2_q;
`endif

endmodule
